stream_out_fifo: RTL
====================

Name: stream_out_fifo

Overview:
- Elastic output buffer that sits directly downstream of the accelerator's result streaming stage (buffer_ctrl/stream_ctrl), between the accelerator top and the DMA S2MM stream port.
- Absorbs DMA backpressure so result words and their TLAST marker are never lost.
- First-word-fall-through FIFO with frame bookkeeping: counts completed frames and pulses when a frame's last word leaves.
- Exposes an almost-full flag so the upstream stream control can throttle early.

Parameters:
- DATA_W, 64, width of the payload word (matches M_AXIS_TDATA).
- DEPTH_LOG2, 4, log2 of the entry count (16 entries by default).
- AFULL_TH, 12, occupancy at or above which almost_full asserts; legal range 1..2^DEPTH_LOG2.

Ports:
- clk  in  1  stream clock (AXIS_ACLK domain).
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_W  upstream word.
- s_last  in  1  upstream end-of-frame marker.
- s_ready  out  1  FIFO can accept a word this cycle.
- m_valid  out  1  head word valid toward the DMA.
- m_data  out  DATA_W  head word.
- m_last  out  1  end-of-frame marker of the head word.
- m_ready  in  1  DMA accepts the head word.
- count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- almost_full  out  1  count >= AFULL_TH.
- frame_done  out  1  one-cycle pulse: a word with m_last was popped.
- frame_cnt  out  16  number of frames fully popped since reset.

Behaviour:
- Reset (async assert, synchronous deassert handled outside the block) forces these outputs:
  - count=0, m_valid=0, m_data=0, m_last=0, frame_done=0, frame_cnt=0, almost_full=0.
  - Read/write pointers go to 0.
  - s_ready=1 in the first cycle after reset deasserts.
- Storage:
  - 2^DEPTH_LOG2 entries of {last, data}, DATA_W+1 bits each.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - count tracks occupancy; full ⇔ count==2^DEPTH_LOG2, empty ⇔ count==0.
- Handshakes:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - s_ready = ~full, decoded from the registered count only; no combinational path from m_ready.
- Output:
  - m_valid/m_data/m_last are combinational reads of the head entry; m_valid = ~empty.
  - Head data must stay stable while m_valid=1 and m_ready=0 (AXI-Stream rule).
- Latency: a word pushed at rising edge N is presented on m_* during the cycle after edge N. No same-cycle bypass from s_* to m_*.
- Simultaneous push and pop, with 0<count<full: count unchanged, both pointers advance.
- When full, s_ready=0, so a push is impossible even if pop occurs. A pop in that cycle makes s_ready=1 in the next cycle.
- When empty, pop is impossible because m_valid=0. A push makes count=1 in the next cycle.
- count update: count_next = count + push − pop, evaluated every cycle.
- almost_full is registered from count_next, so it is aligned with count.
- frame_done: registered pulse, high for exactly one cycle after any edge where pop & m_last.
- frame_cnt:
  - Increments on the same edge that sets frame_done.
  - Wraps 0xFFFF→0x0000 with no saturation.
- s_last is stored verbatim. Frames of any length, including single-word frames (s_last on every word), are legal.
- Upstream must not drop s_valid before handshake; the block does not check this.
- Reset asserted mid-frame:
  - All contents are discarded and frame_cnt clears.
  - No frame_done is emitted for the discarded partial frame.
- Arithmetic is unsigned throughout; no overflow exists on count because push is gated by full.

Test Plan:
- Reset, then push 3 words 0x1,0x2,0x3 (last on 0x3) with m_ready=1 → m_data sequence 0x1,0x2,0x3 starting one cycle after the first push; m_last only on 0x3; frame_done one pulse; frame_cnt=1; count returns to 0.
- Fill with m_ready=0, 16 pushes of 0x10..0x1F → count=16, s_ready=0 on cycle 17, almost_full=1 from count=12. Then one pop with s_valid=1 → s_ready=1 the next cycle, and 0x20 is accepted.
- Hold count=8, drive push and pop every cycle for 40 cycles with an incrementing payload → count stays 8, output order is strictly incrementing, and pointers wrap with no gap or duplicate.
- Random m_ready (50%) and s_valid (70%) for 10,000 words in 37 frames → scoreboard matches data/last exactly, frame_cnt=37, head stable whenever m_ready=0.
- Assert rst for 1 cycle with count=5 mid-frame → count=0, m_valid=0, frame_cnt=0, and no frame_done pulse. The next frame of 2 words is passed correctly.
- Preload frame_cnt to 0xFFFF via 65,535 single-word frames, then one more → frame_cnt=0x0000 and frame_done pulses.

Source files
------------

// File: rtl/stream_out_fifo.sv
// stream_out_fifo: first-word-fall-through elastic buffer between the result
// streaming stage and the DMA S2MM port. Carries TLAST alongside each word,
// flags almost-full for early upstream throttling, and counts completed frames.
module stream_out_fifo #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned AFULL_TH   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [DATA_W-1:0]     s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [DATA_W-1:0]     m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  almost_full,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam int unsigned PTR_W = DEPTH_LOG2;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               afull_q, afull_d;
   logic               frame_done_q, frame_done_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;

   entry_t             head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   // Flags come from the registered count only, so s_ready never depends on m_ready.
   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      empty   = (count_q == '0);
      head    = mem_q[rd_ptr_q];
      s_ready = ~full;
      m_valid = ~empty;
      m_data  = empty ? '0 : head.data;
      m_last  = empty ? 1'b0 : head.last;
      push    = s_valid & ~full;
      pop     = m_ready & ~empty;
   end

   // Next-state for pointers, occupancy and frame bookkeeping.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      afull_d      = 1'b0;
      frame_done_d = pop & head.last;
      frame_cnt_d  = frame_cnt_q + 16'(pop & head.last);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      afull_d = (count_d >= CNT_W'(AFULL_TH));
   end

   // Storage array; contents need no reset because empty gates the head read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{last: s_last, data: s_data};
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         afull_q      <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         afull_q      <= afull_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign count       = count_q;
   assign almost_full = afull_q;
   assign frame_done  = frame_done_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
